// File: rtl/reg_file.sv
// ============================================================================
//  Module   : reg_file
//  Purpose  : 32x32 register file, two async read ports, one sync write port,
//             with written-since-reset bitmap and committed-write counter.
//  Option   : REG_FILE_BYPASS_EN enables same-cycle write-through on reads.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [DATA_W-1:0] writeData,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2,
   output logic              written1,
   output logic              written2,
   output logic [CNT_W-1:0]  writeCount
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  written_q;
   logic [DEPTH-1:0]  written_d;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_d;
   logic              w_commit;

   // Written as a pure AND so an X address/data with RegWrite=0 stays inert.
   assign w_commit = RegWrite && (writeReg != '0);

   always_comb begin
      written_d = written_q;
      count_d   = count_q;
      if (w_commit) begin
         written_d[writeReg] = 1'b1;
         count_d             = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         written_q <= '0;
         count_q   <= '0;
      end else begin
         if (w_commit) begin
            regs_q[writeReg] <= writeData;
         end
         written_q <= written_d;
         count_q   <= count_d;
      end
   end

   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [ADDR_W-1:0] raddr;
         logic [DATA_W-1:0] rdata;
         logic              rwritten;

         assign raddr = (p == 0) ? readReg1 : readReg2;

         always_comb begin
            rdata    = '0;
            rwritten = 1'b0;
            if (raddr != '0) begin
               rdata    = regs_q[raddr];
               rwritten = written_q[raddr];
`ifdef REG_FILE_BYPASS_EN
               if (w_commit && (writeReg == raddr)) begin
                  rdata    = writeData;
                  rwritten = 1'b1;
               end
`endif
            end
         end
      end
   endgenerate

   assign readData1  = g_port[0].rdata;
   assign readData2  = g_port[1].rdata;
   assign written1   = g_port[0].rwritten;
   assign written2   = g_port[1].rwritten;
   assign writeCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  Module   : tb_reg_file
//  Purpose  : Self-checking bench for reg_file (CNT_W=4 to exercise wrap).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic        w1;
      logic        w2;
      logic [3:0]  cnt;
   } out_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      out_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  readReg1, readReg2, writeReg;
   logic        RegWrite;
   logic [31:0] writeData;
   logic [31:0] readData1, readData2;
   logic        written1, written2;
   logic [3:0]  writeCount;

   int n_checks = 0;
   int n_fail   = 0;
   out_t sb[$];
   vec_t vecs[9];

   reg_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .readReg1(readReg1), .readReg2(readReg2),
      .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
      .readData1(readData1), .readData2(readData2),
      .written1(written1), .written2(written2),
      .writeCount(writeCount)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic compare_pop(input string tag);
      out_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got %h expected entry", tag, readData1);
      end else begin
         e = sb.pop_front();
         chk({tag, ".readData1"}, readData1, e.d1);
         chk({tag, ".readData2"}, readData2, e.d2);
         chk({tag, ".written1"}, {31'b0, written1}, {31'b0, e.w1});
         chk({tag, ".written2"}, {31'b0, written2}, {31'b0, e.w2});
         chk({tag, ".writeCount"}, {28'b0, writeCount}, {28'b0, e.cnt});
      end
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2);
      RegWrite  = we;
      writeReg  = wa;
      writeData = wd;
      readReg1  = r1;
      readReg2  = r2;
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      drive(v.we, v.wa, v.wd, v.r1, v.r2);
      sb.push_back(v.e);
      @(posedge clk);
      #1;
      compare_pop(tag);
   endtask

   initial begin
      vec_t v;
      out_t zero_o;
      zero_o = '{32'h0, 32'h0, 1'b0, 1'b0, 4'd0};

      vecs[0] = '{1'b1, 5'd8,  32'h12345678, 5'd8, 5'd9, '{32'h12345678, 32'h0,        1'b1, 1'b0, 4'd1}};
      vecs[1] = '{1'b1, 5'd9,  32'hFFFFFFFF, 5'd8, 5'd9, '{32'h12345678, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd2}};
      vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0, 5'd8, '{32'h0,        32'h12345678, 1'b0, 1'b1, 4'd2}};
      vecs[3] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd7, '{32'h0,        32'h0,        1'b0, 1'b0, 4'd2}};
      vecs[4] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd7, '{32'h0,        32'h0,        1'b0, 1'b0, 4'd2}};
      vecs[5] = '{1'b0, 5'd7,  32'hA5A5A5A5, 5'd7, 5'd7, '{32'h0,        32'h0,        1'b0, 1'b0, 4'd2}};
      vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd0, '{32'hCAFEF00D, 32'h0,       1'b1, 1'b0, 4'd3}};
      vecs[7] = '{1'b1, 5'd8,  32'h0BADC0DE, 5'd8, 5'd8, '{32'h0BADC0DE, 32'h0BADC0DE, 1'b1, 1'b1, 4'd4}};
      vecs[8] = '{1'b0, 5'bx,  32'bx,        5'd8, 5'd9, '{32'h0BADC0DE, 32'hFFFFFFFF, 1'b1, 1'b1, 4'd4}};

      // Reset held low with an active write request on the inputs.
      rst_n = 1'b0;
      drive(1'b1, 5'd3, 32'h11111111, 5'd3, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(zero_o);
      compare_pop("reset_hold");
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
      rst_n = 1'b1;
      #1;
      sb.push_back(zero_o);
      compare_pop("reset_release");

      for (int i = 0; i < 9; i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Same-cycle read/write of r5.
      v = '{1'b1, 5'd5, 32'h1, 5'd5, 5'd0, '{32'h1, 32'h0, 1'b1, 1'b0, 4'd5}};
      step(v, "r5_init");
      @(negedge clk);
      drive(1'b1, 5'd5, 32'h2, 5'd5, 5'd0);
`ifdef REG_FILE_BYPASS_EN
      sb.push_back('{32'h2, 32'h0, 1'b1, 1'b0, 4'd5});
`else
      sb.push_back('{32'h1, 32'h0, 1'b1, 1'b0, 4'd5});
`endif
      #1;
      compare_pop("r5_pre_edge");
      sb.push_back('{32'h2, 32'h0, 1'b1, 1'b0, 4'd6});
      @(posedge clk);
      #1;
      compare_pop("r5_post_edge");

      // Reset coincident with a write edge: the write is lost.
      @(negedge clk);
      drive(1'b1, 5'd2, 32'h77777777, 5'd2, 5'd5);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      sb.push_back(zero_o);
      compare_pop("reset_on_edge");
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd5);
      rst_n = 1'b1;
      #1;
      sb.push_back(zero_o);
      compare_pop("after_edge_reset");

      // 17 writes to r1 with a 4-bit counter.
      for (int i = 0; i < 17; i++) begin
         v = '{1'b1, 5'd1, 32'h100 + i, 5'd1, 5'd0,
               '{32'h100 + i, 32'h0, 1'b1, 1'b0, 4'((i + 1) % 16)}};
         step(v, $sformatf("wrap%0d", i));
      end

      // Asynchronous reset between edges.
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.push_back(zero_o);
      compare_pop("async_reset_mid");
      @(negedge clk);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
